// File: rtl/bp_me_wormhole_lce_cmd_receiver_pkg.sv
// Shared types and configuration for the wormhole LCE command receiver:
// processor config lookup, LCE command / wormhole packet layouts, and the
// receiver FSM state encoding.
package bp_me_wormhole_lce_cmd_receiver_pkg;

  typedef enum logic [0:0] {
    e_bp_inv_cfg = 1'b0
  } bp_params_e;

  localparam int unsigned coh_noc_flit_width_p = 64;
  localparam int unsigned coh_noc_len_width_p  = 4;
  localparam int unsigned coh_noc_cord_width_p = 6;
  localparam int unsigned coh_noc_cid_width_p  = 2;

  localparam int unsigned lce_cmd_data_width_lp = 512;
  localparam int unsigned lce_cmd_addr_width_lp = 22;
  localparam int unsigned lce_id_width_lp       = 3;

  typedef struct packed {
    int unsigned flit_width;
    int unsigned len_width;
    int unsigned cord_width;
    int unsigned cid_width;
  } bp_proc_param_s;

  function automatic bp_proc_param_s bp_proc_param(bp_params_e p);
    bp_proc_param_s c;
    c.flit_width = coh_noc_flit_width_p;
    c.len_width  = coh_noc_len_width_p;
    c.cord_width = coh_noc_cord_width_p;
    c.cid_width  = coh_noc_cid_width_p;
    case (p)
      e_bp_inv_cfg: c.flit_width = coh_noc_flit_width_p;
      default:      c.flit_width = coh_noc_flit_width_p;
    endcase
    return c;
  endfunction

  function automatic int unsigned cdiv(int unsigned a, int unsigned b);
    return (a + b - 1) / b;
  endfunction

  function automatic int unsigned bsg_wormhole_concentrator_packet_width
    (int unsigned cord_w, int unsigned len_w, int unsigned cid_w, int unsigned payload_w);
    return cord_w + len_w + cid_w + payload_w;
  endfunction

  typedef enum logic [3:0] {
    e_lce_cmd_sync           = 4'd0,
    e_lce_cmd_set_clear      = 4'd1,
    e_lce_cmd_transfer       = 4'd2,
    e_lce_cmd_set_tag        = 4'd3,
    e_lce_cmd_set_tag_wakeup = 4'd4,
    e_lce_cmd_inv            = 4'd5,
    e_lce_cmd_data           = 4'd6,
    e_lce_cmd_uc_data        = 4'd7,
    e_lce_cmd_uc_st_done     = 4'd8
  } bp_lce_cmd_type_e;

  typedef enum logic [2:0] {
    e_mem_msg_size_1  = 3'd0,
    e_mem_msg_size_2  = 3'd1,
    e_mem_msg_size_4  = 3'd2,
    e_mem_msg_size_8  = 3'd3,
    e_mem_msg_size_16 = 3'd4,
    e_mem_msg_size_32 = 3'd5,
    e_mem_msg_size_64 = 3'd6
  } bp_mem_msg_size_e;

  typedef struct packed {
    logic [lce_cmd_addr_width_lp-1:0] addr;
    logic [lce_id_width_lp-1:0]       dst_id;
    bp_mem_msg_size_e                 size;
    bp_lce_cmd_type_e                 msg_type;
  } bp_lce_cmd_header_s;

  typedef struct packed {
    logic [lce_cmd_data_width_lp-1:0] data;
    bp_lce_cmd_header_s               header;
  } bp_lce_cmd_s;

  localparam int unsigned lce_cmd_width_lp = $bits(bp_lce_cmd_s);

  // Wormhole concentrator packet: routing fields in the low bits, payload above.
  typedef struct packed {
    bp_lce_cmd_s                     payload;
    logic [coh_noc_cid_width_p-1:0]  cid;
    logic [coh_noc_len_width_p-1:0]  len;
    logic [coh_noc_cord_width_p-1:0] cord;
  } bp_lce_cmd_packet_s;

  typedef enum logic [1:0] {
    e_rx_idle = 2'd0,
    e_rx_body = 2'd1,
    e_rx_full = 2'd2
  } bp_wh_rx_state_e;

endpackage

// File: rtl/bp_me_wormhole_lce_cmd_receiver_if.sv
// Link-side flit handshake and consumer-side command handshake of the receiver.
interface bp_me_wormhole_lce_cmd_receiver_if;
  import bp_me_wormhole_lce_cmd_receiver_pkg::*;

  logic [coh_noc_flit_width_p-1:0] link_data_i;
  logic                            link_v_i;
  logic                            link_ready_o;
  bp_lce_cmd_s                     lce_cmd_o;
  logic                            lce_cmd_v_o;
  logic                            lce_cmd_yumi_i;

  modport slave (
    input  link_data_i, link_v_i, lce_cmd_yumi_i,
    output link_ready_o, lce_cmd_o, lce_cmd_v_o
  );

  modport master (
    output link_data_i, link_v_i, lce_cmd_yumi_i,
    input  link_ready_o, lce_cmd_o, lce_cmd_v_o
  );
endinterface

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; clear and up together load 1.
module bsg_counter_clear_up #(
  parameter  int unsigned max_val_p  = 16,
  parameter  int unsigned init_val_p = 0,
  localparam int unsigned width_lp   = $clog2(max_val_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                clear_i,
  input  logic                up_i,
  output logic [width_lp-1:0] count_o
);

  logic [width_lp-1:0] r_count;

  // Count register: async reset to the initial value.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      r_count <= width_lp'(init_val_p);
    else if (clear_i)
      r_count <= width_lp'(up_i);
    else if (up_i)
      r_count <= r_count + width_lp'(1);
  end

  assign count_o = r_count;

endmodule

// File: rtl/bp_me_wormhole_lce_cmd_receiver.sv
// Reassembles wormhole flits into one LCE command. The header flit carries
// the flit count (len); flits past the buffer capacity are consumed but
// dropped, and the finished command is held until the consumer takes it.
module bp_me_wormhole_lce_cmd_receiver
  import bp_me_wormhole_lce_cmd_receiver_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_inv_cfg
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  bp_me_wormhole_lce_cmd_receiver_if.slave      lce_if
);

  localparam bp_proc_param_s cfg_lp          = bp_proc_param(bp_params_p);
  localparam int unsigned    flit_width_lp   = cfg_lp.flit_width;
  localparam int unsigned    len_width_lp    = cfg_lp.len_width;
  localparam int unsigned    cord_width_lp   = cfg_lp.cord_width;
  localparam int unsigned    cid_width_lp    = cfg_lp.cid_width;
  localparam int unsigned    packet_width_lp =
    bsg_wormhole_concentrator_packet_width(cord_width_lp, len_width_lp, cid_width_lp, lce_cmd_width_lp);
  localparam int unsigned    max_flits_lp    = cdiv(packet_width_lp, flit_width_lp);
  localparam int unsigned    buf_width_lp    = max_flits_lp * flit_width_lp;
  localparam int unsigned    cnt_width_lp    = len_width_lp + 1;

  bp_wh_rx_state_e           r_state, w_state_next;
  logic [len_width_lp-1:0]   r_len;
  logic [len_width_lp-1:0]   w_flit_len;
  logic [cnt_width_lp-1:0]   w_count;
  logic [buf_width_lp-1:0]   r_buf;
  bp_lce_cmd_packet_s        w_packet;
  logic                      w_ready, w_v, w_clear, w_up, w_accept;
  logic                      w_unused;

  assign w_flit_len = lce_if.link_data_i[cord_width_lp +: len_width_lp];
  assign w_accept   = lce_if.link_v_i & w_ready;

  // Flit index within the current packet; the extra bit keeps len = all-ones from wrapping.
  bsg_counter_clear_up #(
    .max_val_p (2 ** len_width_lp),
    .init_val_p(0)
  ) u_flit_cnt (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clear_i  (w_clear),
    .up_i     (w_up),
    .count_o  (w_count)
  );

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= e_rx_idle;
    else            r_state <= w_state_next;
  end

  // Next state, handshakes and counter control.
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_v          = 1'b0;
    w_clear      = 1'b0;
    w_up         = 1'b0;
    case (r_state)
      e_rx_idle: begin
        w_ready = 1'b1;
        if (lce_if.link_v_i) begin
          w_clear      = 1'b1;
          w_up         = 1'b1;
          w_state_next = (w_flit_len == '0) ? e_rx_full : e_rx_body;
        end
      end
      e_rx_body: begin
        w_ready = 1'b1;
        if (lce_if.link_v_i) begin
          w_up = 1'b1;
          if (w_count == {1'b0, r_len}) w_state_next = e_rx_full;
        end
      end
      e_rx_full: begin
        w_v = 1'b1;
        if (lce_if.lce_cmd_yumi_i) w_state_next = e_rx_idle;
      end
      default: w_state_next = e_rx_idle;
    endcase
  end

  // Packet length latched from the header flit.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)   r_len <= '0;
    else if (w_clear) r_len <= w_flit_len;
  end

  // Packet buffer: zeroed by the header so short packets read zero-padded;
  // body flits past the last slice fall through the loop and are dropped.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      if (r_state == e_rx_idle) begin
        r_buf                      <= '0;
        r_buf[flit_width_lp-1:0]   <= lce_if.link_data_i;
      end else begin
        for (int unsigned i = 1; i < max_flits_lp; i++) begin
          if (w_count == cnt_width_lp'(i))
            r_buf[i*flit_width_lp +: flit_width_lp] <= lce_if.link_data_i;
        end
      end
    end
  end

  assign w_packet            = r_buf[packet_width_lp-1:0];
  assign lce_if.lce_cmd_o    = w_packet.payload;
  assign lce_if.lce_cmd_v_o  = w_v;
  assign lce_if.link_ready_o = w_ready;

  assign w_unused = ^{r_buf[buf_width_lp-1:packet_width_lp], w_packet.cord, w_packet.len, w_packet.cid};

endmodule
